mux3_to_1_d: RTL and testbench



---
 rtl/mux3_to_1_d.sv | 51 +++++
 tb/tb_mux3_to_1_d.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mux3_to_1_d.sv
// mux3_to_1_d: 3-to-1 n-bit datapath mux with a registered copy and select-error flag
//
// Ports:
//   clk        rising-edge clock for out_q / sel_err_q
//   rst        asynchronous active-high reset of out_q / sel_err_q
//   S          select: 00->x, 01->y, 10->z, 11->illegal
//   x, y, z    n-bit data inputs
//   en         load enable for the registered outputs
//   out        combinational mux result (zero on illegal select)
//   sel_err    combinational illegal-select flag
//   out_q      registered out
//   sel_err_q  registered sel_err
module mux3_to_1_d #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   S,
   input  logic [n-1:0] x,
   input  logic [n-1:0] y,
   input  logic [n-1:0] z,
   input  logic         en,
   output logic [n-1:0] out,
   output logic         sel_err,
   output logic [n-1:0] out_q,
   output logic         sel_err_q
);

   // A case is used rather than nested ternaries so an unknown select yields all-X
   // in simulation instead of a merge of the candidate inputs.
   always_comb begin
      case (S)
         2'b00:   begin out = x;   sel_err = 1'b0; end
         2'b01:   begin out = y;   sel_err = 1'b0; end
         2'b10:   begin out = z;   sel_err = 1'b0; end
         2'b11:   begin out = '0;  sel_err = 1'b1; end
         default: begin out = 'x;  sel_err = 1'bx; end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q     <= '0;
         sel_err_q <= 1'b0;
      end else if (en) begin
         out_q     <= out;
         sel_err_q <= sel_err;
      end
   end

endmodule

// File: tb/tb_mux3_to_1_d.sv
// tb_mux3_to_1_d: directed and randomized self-checking bench for mux3_to_1_d (n=32 and n=8)
module tb_mux3_to_1_d;

   logic        clk, rst, en;
   logic [1:0]  S;
   logic [31:0] x, y, z;
   logic [31:0] out, out_q;
   logic        sel_err, sel_err_q;
   logic [7:0]  out8, out8_q;
   logic        sel_err8, sel_err8_q;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] q_m;
   logic        qe_m;
   logic [7:0]  q8_m;

   mux3_to_1_d #(.n(32)) dut (
      .clk(clk), .rst(rst), .S(S), .x(x), .y(y), .z(z), .en(en),
      .out(out), .sel_err(sel_err), .out_q(out_q), .sel_err_q(sel_err_q)
   );

   mux3_to_1_d #(.n(8)) dut8 (
      .clk(clk), .rst(rst), .S(S), .x(x[7:0]), .y(y[7:0]), .z(z[7:0]), .en(en),
      .out(out8), .sel_err(sel_err8), .out_q(out8_q), .sel_err_q(sel_err8_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: inputs laid out in an array indexed by the select, slot 3 is the illegal zero.
   function automatic logic [31:0] ref_out(input logic [1:0] s, input logic [31:0] a, b, c);
      logic [31:0] v [4];
      v = '{a, b, c, 32'h0};
      return v[s];
   endfunction

   task automatic check_comb(input string tag);
      logic [31:0] e;
      #1;
      e = ref_out(S, x, y, z);
      check({tag, ".out"}, out, e);
      check({tag, ".err"}, {31'b0, sel_err}, {31'b0, S == 2'b11});
      check({tag, ".out8"}, {24'b0, out8}, {24'b0, e[7:0]});
      check({tag, ".err8"}, {31'b0, sel_err8}, {31'b0, S == 2'b11});
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".q"}, out_q, q_m);
      check({tag, ".qe"}, {31'b0, sel_err_q}, {31'b0, qe_m});
      check({tag, ".q8"}, {24'b0, out8_q}, {24'b0, q8_m});
      check({tag, ".qe8"}, {31'b0, sel_err8_q}, {31'b0, qe_m});
   endtask

   // One rising edge: update the model from the pre-edge inputs, check just after, return at negedge.
   task automatic tick(input string tag);
      logic [31:0] e;
      @(posedge clk);
      e = ref_out(S, x, y, z);
      if (rst) begin
         q_m = '0; qe_m = 1'b0; q8_m = '0;
      end else if (en) begin
         q_m = e; qe_m = (S == 2'b11); q8_m = e[7:0];
      end
      #1;
      check_regs(tag);
      @(negedge clk);
   endtask

   task automatic async_reset(input string tag);
      rst = 1'b1;
      #1;
      q_m = '0; qe_m = 1'b0; q8_m = '0;
      check_regs(tag);
   endtask

   initial begin
      clk = 1'b0; rst = 1'b0; en = 1'b0; S = 2'b00; x = '0; y = '0; z = '0;
      q_m = '0; qe_m = 1'b0; q8_m = '0;
      #2;
      async_reset("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic selection and illegal select
      x = 32'h12345678; y = 32'hFFFFFFFF; z = 32'h00000001;
      S = 2'b00; check_comb("t1_s0"); check("t1_s0_abs", out, 32'h12345678);
      S = 2'b01; check_comb("t1_s1"); check("t1_s1_abs", out, 32'hFFFFFFFF);
      S = 2'b10; check_comb("t1_s2"); check("t1_s2_abs", out, 32'h00000001);
      x = 32'h11111111; y = 32'hCCCCCCCC; z = 32'hDDDDBBBB;
      check_comb("t2_zchg"); check("t2_abs", out, 32'hDDDDBBBB);
      S = 2'b00; check_comb("t2_s0"); check("t2_s0_abs", out, 32'h11111111);
      S = 2'b11; check_comb("t3_ill"); check("t3_abs", out, 32'h0);
      check("t3_err_abs", {31'b0, sel_err}, 32'h1);
      S = 2'b01; check_comb("t3_s1");

      // Load a nonzero value so reset has something to clear
      @(negedge clk);
      en = 1'b1; S = 2'b11; tick("pre_ill");
      S = 2'b10; tick("pre_load");
      #2;
      async_reset("t4_async");
      S = 2'b00; x = 32'hA5A5A5A5; check_comb("t4_comb");
      tick("t4_hold1");
      S = 2'b11; tick("t4_hold2");
      check_comb("t4_comb2");
      rst = 1'b0;

      // Load, then hold with en low
      en = 1'b1; S = 2'b01; y = 32'hCCCCCCCC;
      tick("t5_load"); check("t5_abs", out_q, 32'hCCCCCCCC);
      en = 1'b0; S = 2'b00;
      for (int i = 0; i < 3; i++) tick("t5_hold");
      check("t5_hold_abs", out_q, 32'hCCCCCCCC);

      // Narrow instance sweep
      x = 32'h000000A5; y = 32'h0000005A; z = 32'h0000000F;
      for (int i = 0; i < 4; i++) begin
         S = 2'(i);
         check_comb("t6_sweep");
      end

      // Randomized traffic with occasional mid-cycle async reset
      for (int i = 0; i < 300; i++) begin
         rst = 1'b0;
         S = 2'($urandom_range(0, 3));
         x = $urandom; y = $urandom; z = $urandom;
         en = ($urandom_range(0, 3) != 0);
         check_comb("rnd_comb");
         if ($urandom_range(0, 15) == 0) async_reset("rnd_rst");
         tick("rnd_reg");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
